dmem_access_ctrl: RTL and testbench

//  Sequences data-memory accesses for the MEM stage over a valid/ready request + response-valid bus.

---
 rtl/dmem_access_ctrl_pkg.sv | 20 ++
 rtl/dmem_access_ctrl_lane_align.sv | 66 ++++++
 rtl/dmem_access_ctrl.sv | 154 +++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared constants for the MEM-stage data-memory access controller:
// funct3 size/sign encodings, FSM states and byte-enable width.
package dmem_access_ctrl_pkg;

  localparam int DMEM_BE_W = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DONE     = 2'd3
  } dmem_state_e;

endpackage

// File: rtl/dmem_access_ctrl_lane_align.sv
// Combinational byte-lane logic: store enables/data placement, load
// extract and extend, and natural-alignment check for H/W accesses.
module dmem_access_ctrl_lane_align
  import dmem_access_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]           funct3,
  input  logic [1:0]           addr_lo,
  input  logic [XLEN-1:0]      st_data,
  input  logic [XLEN-1:0]      ld_raw,
  output logic [DMEM_BE_W-1:0] st_be,
  output logic [XLEN-1:0]      st_wdata,
  output logic [XLEN-1:0]      ld_data,
  output logic                 misaligned
);

  logic signed [7:0]  ld_byte;
  logic signed [15:0] ld_half;

  always_comb begin
    misaligned = ((funct3 == F3_H || funct3 == F3_HU) && addr_lo[0]) ||
                 ((funct3 == F3_W) && (addr_lo != 2'b00));
  end

  // Stores replicate the low-aligned datum across all lanes; be picks the lane.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << {addr_lo[1], 1'b0};
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = st_data;
      end
    endcase
  end

  always_comb begin
    ld_byte = ld_raw[7:0];
    case (addr_lo)
      2'd0:    ld_byte = ld_raw[7:0];
      2'd1:    ld_byte = ld_raw[15:8];
      2'd2:    ld_byte = ld_raw[23:16];
      default: ld_byte = ld_raw[31:24];
    endcase
    ld_half = addr_lo[1] ? ld_raw[31:16] : ld_raw[15:0];

    ld_data = ld_raw;
    case (funct3)
      F3_B:    ld_data = XLEN'(ld_byte);
      F3_H:    ld_data = XLEN'(ld_half);
      F3_BU:   ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      F3_HU:   ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: issues valid/ready requests, waits for
// load responses, stalls the front pipeline and bubbles MEM/WB meanwhile.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 exm_memread,
  input  logic                 exm_memwrite,
  input  logic [2:0]           exm_funct3,
  input  logic [XLEN-1:0]      exm_addr,
  input  logic [XLEN-1:0]      exm_wdata,
  output logic                 dmem_req_valid,
  input  logic                 dmem_req_ready,
  output logic                 dmem_req_we,
  output logic [XLEN-1:0]      dmem_req_addr,
  output logic [XLEN-1:0]      dmem_req_wdata,
  output logic [DMEM_BE_W-1:0] dmem_req_be,
  input  logic                 dmem_rsp_valid,
  input  logic [XLEN-1:0]      dmem_rsp_rdata,
  output logic [XLEN-1:0]      mem_read_data,
  output logic                 mem_stall,
  output logic                 mem_bubble,
  output logic                 misalign_fault,
  output logic                 timeout_fault
);

  if (XLEN != 32) begin : g_xlen_check
    $error("dmem_access_ctrl: only XLEN=32 is supported");
  end

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);

  dmem_state_e          state;
  logic [CNT_W-1:0]     tmo_cnt;
  logic [XLEN-1:0]      rdata_q;
  logic                 timeout_q;

  logic                 access;
  logic                 misaligned;
  logic                 tmo_hit;
  logic [DMEM_BE_W-1:0] st_be;
  logic [XLEN-1:0]      st_wdata;
  logic [XLEN-1:0]      ld_data;

  dmem_access_ctrl_lane_align #(.XLEN(XLEN)) u_lane_align (
    .funct3     (exm_funct3),
    .addr_lo    (exm_addr[1:0]),
    .st_data    (exm_wdata),
    .ld_raw     (rdata_q),
    .st_be      (st_be),
    .st_wdata   (st_wdata),
    .ld_data    (ld_data),
    .misaligned (misaligned)
  );

  assign access  = exm_memread | exm_memwrite;
  assign tmo_hit = (tmo_cnt >= CNT_LAST);

  // Control outputs decode state plus the live EX/MEM instruction so that an
  // IDLE access requests in its first cycle; everything is forced low in reset.
  always_comb begin
    dmem_req_valid = 1'b0;
    mem_stall      = 1'b0;
    mem_bubble     = 1'b0;
    misalign_fault = 1'b0;
    mem_read_data  = '0;
    unique case (state)
      ST_IDLE: begin
        if (access && misaligned) begin
          misalign_fault = 1'b1;
          mem_bubble     = 1'b1;
        end else if (access) begin
          dmem_req_valid = 1'b1;
          mem_stall      = 1'b1;
          mem_bubble     = 1'b1;
        end
      end
      ST_REQ: begin
        dmem_req_valid = 1'b1;
        mem_stall      = 1'b1;
        mem_bubble     = 1'b1;
      end
      ST_WAIT_RSP: begin
        mem_stall  = 1'b1;
        mem_bubble = 1'b1;
      end
      ST_DONE: mem_read_data = ld_data;
    endcase
    if (!rst_n) begin
      dmem_req_valid = 1'b0;
      mem_stall      = 1'b0;
      mem_bubble     = 1'b0;
      misalign_fault = 1'b0;
      mem_read_data  = '0;
    end
  end

  assign dmem_req_we    = dmem_req_valid & exm_memwrite;
  assign dmem_req_addr  = dmem_req_valid ? {exm_addr[XLEN-1:2], 2'b00} : '0;
  assign dmem_req_wdata = dmem_req_valid ? st_wdata : '0;
  assign dmem_req_be    = dmem_req_valid ? st_be : '0;
  assign timeout_fault  = timeout_q;

  // A handshake or response arriving on the deadline cycle wins over timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tmo_cnt   <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          tmo_cnt <= '0;
          if (access && !misaligned) begin
            if (!dmem_req_ready)  state <= ST_REQ;
            else if (exm_memread) state <= ST_WAIT_RSP;
            else                  state <= ST_DONE;
          end
        end
        ST_REQ: begin
          if (tmo_cnt != CNT_MAX) tmo_cnt <= tmo_cnt + 1'b1;
          if (dmem_req_ready) begin
            state <= exm_memread ? ST_WAIT_RSP : ST_DONE;
          end else if (tmo_hit) begin
            state     <= ST_DONE;
            rdata_q   <= '0;
            timeout_q <= 1'b1;
          end
        end
        ST_WAIT_RSP: begin
          if (tmo_cnt != CNT_MAX) tmo_cnt <= tmo_cnt + 1'b1;
          if (dmem_rsp_valid) begin
            state   <= ST_DONE;
            rdata_q <= dmem_rsp_rdata;
          end else if (tmo_hit) begin
            state     <= ST_DONE;
            rdata_q   <= '0;
            timeout_q <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized scoreboard bench for dmem_access_ctrl with a small-timeout build.
module tb_dmem_access_ctrl;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exm_memread, exm_memwrite;
  logic [2:0]  exm_funct3;
  logic [31:0] exm_addr, exm_wdata;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [31:0] dmem_req_addr, dmem_req_wdata;
  logic [3:0]  dmem_req_be;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_rdata;
  logic [31:0] mem_read_data;
  logic        mem_stall, mem_bubble, misalign_fault, timeout_fault;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.XLEN(32), .TIMEOUT_CYC(TMO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .exm_memread    (exm_memread),
    .exm_memwrite   (exm_memwrite),
    .exm_funct3     (exm_funct3),
    .exm_addr       (exm_addr),
    .exm_wdata      (exm_wdata),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_req_we    (dmem_req_we),
    .dmem_req_addr  (dmem_req_addr),
    .dmem_req_wdata (dmem_req_wdata),
    .dmem_req_be    (dmem_req_be),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_rdata (dmem_rsp_rdata),
    .mem_read_data  (mem_read_data),
    .mem_stall      (mem_stall),
    .mem_bubble     (mem_bubble),
    .misalign_fault (misalign_fault),
    .timeout_fault  (timeout_fault)
  );

  typedef struct {
    logic        is_mis;
    logic        is_load;
    int          stall_cyc;
    int          req_cyc;
    logic        tmo;
    logic [31:0] data;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  logic mon_en = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
  endfunction

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> (8 * a);
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return sh & 32'h0000_00FF;
      3'b101:  return sh & 32'h0000_FFFF;
      default: return w;
    endcase
  endfunction

  // Reference model: derive the whole outcome of one access from its size,
  // address and the memory's ready/response latencies.
  function automatic exp_t model(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, input int r, input int d,
                                 input logic [31:0] rdata);
    exp_t e;
    int   nbytes, lim, rsp_idx;
    nbytes    = 1 << f3[1:0];
    e.is_mis  = (addr % nbytes) != 0;
    e.is_load = ld;
    e.addr    = addr & ~32'd3;
    e.be      = 4'(((1 << nbytes) - 1) << (addr % 4));
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wd[8*(i % nbytes) +: 8];
    e.data = 32'd0;
    e.tmo  = 1'b0;
    if (!ld) begin
      e.tmo       = (r > TMO);
      e.stall_cyc = e.tmo ? TMO + 1 : r + 1;
      e.req_cyc   = e.stall_cyc;
    end else if (r > TMO) begin
      e.tmo       = 1'b1;
      e.stall_cyc = TMO + 1;
      e.req_cyc   = TMO + 1;
    end else begin
      lim       = (r == TMO) ? TMO + 1 : TMO;
      rsp_idx   = r + 1 + d;
      e.req_cyc = r + 1;
      if (rsp_idx <= lim) begin
        e.stall_cyc = rsp_idx + 1;
        e.data      = fmt_load(f3, addr[1:0], rdata);
      end else begin
        e.tmo       = 1'b1;
        e.stall_cyc = lim + 1;
      end
    end
    return e;
  endfunction

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      exm_memread    = 1'b0;
      exm_memwrite   = 1'b0;
      dmem_req_ready = 1'($urandom_range(0, 1));
      dmem_rsp_valid = ($urandom_range(0, 3) == 0);
      dmem_rsp_rdata = $urandom;
    end
  endtask

  task automatic run_txn(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int r, input int d, input logic [31:0] rdata);
    logic done;
    exp_q.push_back(model(ld, f3, addr, wd, r, d, rdata));
    done = 1'b0;
    @(negedge clk);
    exm_memread  = ld;
    exm_memwrite = ~ld;
    exm_funct3   = f3;
    exm_addr     = addr;
    exm_wdata    = wd;
    for (int t = 0; t < 200; t++) begin
      if (t > 0) @(negedge clk);
      dmem_req_ready = (t == r);
      if (ld && t == r + 1 + d) begin
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = rdata;
      end else begin
        dmem_rsp_valid = (t <= r) && ($urandom_range(0, 2) == 0);
        dmem_rsp_rdata = $urandom;
      end
      #1;
      if (!mem_stall) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      chk("txn_complete", 32'd0, 32'd1);
      $display("FAIL bench_bound: access never completed, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1, "stalled access");
    end
  endtask

  // Monitor: per-cycle invariants, request stability, and scoreboard pop at completion.
  initial begin
    int          st_cnt, rq_cnt;
    logic        prev_stall;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_be;
    logic        c_we;
    exp_t        e;
    st_cnt = 0; rq_cnt = 0; prev_stall = 1'b0;
    c_addr = '0; c_wdata = '0; c_be = '0; c_we = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!mon_en) begin
        st_cnt = 0; rq_cnt = 0; prev_stall = 1'b0;
      end else begin
        chk("bubble_inv", {31'd0, mem_bubble}, {31'd0, mem_stall | misalign_fault});
        if (mem_stall) st_cnt++;
        if (dmem_req_valid) begin
          if (rq_cnt == 0) begin
            c_addr = dmem_req_addr; c_wdata = dmem_req_wdata; c_be = dmem_req_be; c_we = dmem_req_we;
          end else begin
            chk("req_stable", {dmem_req_addr ^ c_addr}, 32'd0);
            chk("req_stable_be_we", {27'd0, dmem_req_we, dmem_req_be}, {27'd0, c_we, c_be});
            chk("req_stable_wdata", dmem_req_wdata, c_wdata);
          end
          rq_cnt++;
        end
        if (misalign_fault || (!mem_stall && prev_stall)) begin
          if (exp_q.size() == 0) begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
          end else begin
            e = exp_q.pop_front();
            chk("kind_misalign", {31'd0, misalign_fault}, {31'd0, e.is_mis});
            if (e.is_mis) begin
              chk("mis_no_req", rq_cnt + {31'd0, dmem_req_valid}, 32'd0);
              chk("mis_stall", {31'd0, mem_stall}, 32'd0);
            end else begin
              chk("stall_cycles", st_cnt, e.stall_cyc);
              chk("req_cycles", rq_cnt, e.req_cyc);
              chk("timeout_fault", {31'd0, timeout_fault}, {31'd0, e.tmo});
              chk("req_addr", c_addr, e.addr);
              chk("req_we", {31'd0, c_we}, {31'd0, ~e.is_load});
              if (e.is_load) begin
                chk("load_data", mem_read_data, e.data);
              end else begin
                chk("store_be", {28'd0, c_be}, {28'd0, e.be});
                chk("store_wdata", c_wdata, e.wdata);
              end
            end
          end
          st_cnt = 0;
          rq_cnt = 0;
        end else begin
          chk("idle_data_zero", mem_read_data, 32'd0);
          chk("idle_no_timeout", {31'd0, timeout_fault}, 32'd0);
        end
        prev_stall = mem_stall;
      end
    end
  end

  initial begin
    logic        ld;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          r, d;
    rst_n = 1'b0;
    exm_memread = 1'b1; exm_memwrite = 1'b0; exm_funct3 = 3'b010;
    exm_addr = 32'h100; exm_wdata = 32'h0;
    dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctrl", {22'd0, dmem_req_valid, dmem_req_we, dmem_req_be, mem_stall, mem_bubble,
                       misalign_fault, timeout_fault}, 32'd0);
    chk("reset_req_addr", dmem_req_addr, 32'd0);
    chk("reset_read_data", mem_read_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exm_memread = 1'b0; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    mon_en = 1'b1;

    run_txn(1'b1, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF);
    idle_gap(1);
    run_txn(1'b1, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80FF_FF00);
    run_txn(1'b1, 3'b100, 32'h103, 32'h0, 0, 1, 32'h80FF_FF00);
    run_txn(1'b1, 3'b101, 32'h102, 32'h0, 1, 0, 32'h80FF_FF00);
    run_txn(1'b0, 3'b000, 32'h101, 32'h0000_00AB, 3, 0, 32'h0);
    run_txn(1'b1, 3'b010, 32'h102, 32'h0, 0, 0, 32'h1234_5678);
    run_txn(1'b0, 3'b001, 32'h203, 32'h0000_BEEF, 0, 0, 32'h0);
    run_txn(1'b1, 3'b010, 32'h300, 32'h0, 0, 50, 32'h5555_AAAA);
    run_txn(1'b0, 3'b010, 32'h304, 32'h0102_0304, 12, 0, 32'h0);
    run_txn(1'b1, 3'b010, 32'h308, 32'h0, TMO, 0, 32'h0BAD_CAFE);
    run_txn(1'b0, 3'b001, 32'h30A, 32'h1234_5678, TMO, 0, 32'h0);
    idle_gap(2);

    for (int i = 0; i < 300; i++) begin
      ld   = ($urandom_range(0, 9) < 6);
      f3   = ld ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 2));
      if (ld && f3 == 3'd3) f3 = 3'b100;
      if (ld && f3 == 3'd4 && $urandom_range(0, 1) == 1) f3 = 3'b101;
      addr = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) addr = addr & ~(32'd1 << f3[1:0]) + 32'd0 & ~((32'd1 << f3[1:0]) - 1);
      r    = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 11) : $urandom_range(0, 3);
      d    = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 11) : $urandom_range(0, 3);
      run_txn(ld, f3, addr, $urandom, r, d, $urandom);
      if ($urandom_range(0, 1) == 1) idle_gap($urandom_range(1, 3));
    end
    idle_gap(2);

    // Asynchronous reset during WAIT_RSP, then a late response that must be dropped.
    @(negedge clk);
    mon_en = 1'b0;
    exm_memread = 1'b1; exm_memwrite = 1'b0; exm_funct3 = 3'b010; exm_addr = 32'h200;
    dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    #1;
    chk("wait_rsp_stall", {30'd0, mem_stall, dmem_req_valid}, 32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_ctrl", {22'd0, dmem_req_valid, dmem_req_we, dmem_req_be, mem_stall, mem_bubble,
                             misalign_fault, timeout_fault}, 32'd0);
    chk("async_reset_data", mem_read_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exm_memread = 1'b0;
    dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'h1234_5678;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    #1;
    chk("late_rsp_ignored", {mem_read_data[31:1], mem_stall | mem_bubble | timeout_fault}, 32'd0);
    @(negedge clk);
    mon_en = 1'b1;
    run_txn(1'b1, 3'b010, 32'h400, 32'h0, 0, 0, 32'hCAFE_F00D);
    idle_gap(3);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
